// File: rtl/decoder_scan_pipe.sv
// Two-stage predecoded IN_W-to-2^IN_W one-hot decoder with valid/ready flow control and an
// automatic scan sequencer. Define DECODER_SCAN_ACTIVE_LOW_EN for one-cold (inverted) output.
module decoder_scan_pipe #(
   parameter int IN_W  = 6,
   parameter int LO_W  = 3,
   parameter int DWELL = 4,
   parameter int CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 mode,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [IN_W-1:0]      in,
   input  logic                 scan_start,
   input  logic [IN_W-1:0]      scan_last,
   input  logic                 scan_loop,
   input  logic                 scan_stop,
   output logic [(1<<IN_W)-1:0] out,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 scan_busy,
   output logic                 scan_done
);

   localparam int OUT_W = 1 << IN_W;
   localparam int HI_W  = IN_W - LO_W;
   localparam int LO_N  = 1 << LO_W;
   localparam int HI_N  = 1 << HI_W;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DWELL - 1);

`ifdef DECODER_SCAN_ACTIVE_LOW_EN
   localparam logic [OUT_W-1:0] OFF_CODE = '1;
`else
   localparam logic [OUT_W-1:0] OFF_CODE = '0;
`endif

   typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_DRAIN} state_t;

   state_t            state_q, state_d;
   logic [IN_W-1:0]   idx_q, idx_d;
   logic [IN_W-1:0]   last_q, last_d;
   logic              loop_q, loop_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              s1_valid_q, s1_valid_d;
   logic [LO_N-1:0]   lo_q, lo_d;
   logic [HI_N-1:0]   hi_q, hi_d;
   logic              out_valid_q, out_valid_d;
   logic [OUT_W-1:0]  out_q, out_d;
   logic              done_q, done_d;

   logic              stall;
   logic              ready_c;
   logic              push;
   logic [IN_W-1:0]   push_idx;
   logic [OUT_W-1:0]  dec;

   for (genvar h = 0; h < HI_N; h++) begin : g_hi
      for (genvar l = 0; l < LO_N; l++) begin : g_lo
         assign dec[h*LO_N + l] = hi_q[h] & lo_q[l];
      end
   end

   // Handshakes: a beat transfers on a rising edge where valid and ready are both high.
   // Producers hold valid and payload until then; in_ready follows out_ready combinationally.
   always_comb begin
      stall       = out_valid_q & ~out_ready;
      ready_c     = ~stall & (state_q == ST_IDLE);
      push        = ((state_q == ST_SCAN) & ~stall & (cnt_q == '0)) | (in_valid & ready_c);
      push_idx    = (state_q == ST_SCAN) ? idx_q : in;

      state_d     = state_q;
      idx_d       = idx_q;
      last_d      = last_q;
      loop_d      = loop_q;
      cnt_d       = cnt_q;
      done_d      = 1'b0;
      s1_valid_d  = s1_valid_q;
      lo_d        = lo_q;
      hi_d        = hi_q;
      out_valid_d = out_valid_q;
      out_d       = out_q;

      case (state_q)
         ST_IDLE: begin
            if (scan_start && mode) begin
               last_d  = scan_last;
               loop_d  = scan_loop;
               idx_d   = '0;
               cnt_d   = '0;
               state_d = ST_SCAN;
            end
         end
         ST_SCAN: begin
            // The dwell count only advances on unstalled cycles, so a stall stretches the step.
            if (!stall) begin
               if (cnt_q == CNT_MAX) begin
                  cnt_d = '0;
                  if (scan_stop) begin
                     state_d = ST_DRAIN;
                  end else if (idx_q == last_q) begin
                     if (loop_q) idx_d = '0;
                     else        state_d = ST_DRAIN;
                  end else begin
                     idx_d = idx_q + IN_W'(1);
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         ST_DRAIN: begin
            if (!s1_valid_q && !out_valid_q) begin
               done_d  = 1'b1;
               idx_d   = '0;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (!stall) begin
         s1_valid_d  = push;
         lo_d        = push ? (LO_N'(1) << push_idx[LO_W-1:0]) : '0;
         hi_d        = push ? (HI_N'(1) << push_idx[IN_W-1:LO_W]) : '0;
         out_valid_d = s1_valid_q;
         out_d       = s1_valid_q ? (dec ^ OFF_CODE) : OFF_CODE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         last_q      <= '0;
         loop_q      <= 1'b0;
         cnt_q       <= '0;
         done_q      <= 1'b0;
         s1_valid_q  <= 1'b0;
         lo_q        <= '0;
         hi_q        <= '0;
         out_valid_q <= 1'b0;
         out_q       <= OFF_CODE;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         last_q      <= last_d;
         loop_q      <= loop_d;
         cnt_q       <= cnt_d;
         done_q      <= done_d;
         s1_valid_q  <= s1_valid_d;
         lo_q        <= lo_d;
         hi_q        <= hi_d;
         out_valid_q <= out_valid_d;
         out_q       <= out_d;
      end
   end

   assign in_ready  = ready_c;
   assign out       = out_q;
   assign out_valid = out_valid_q;
   assign scan_busy = (state_q != ST_IDLE);
   assign scan_done = done_q;

endmodule

// File: tb/tb_decoder_scan_pipe.sv
// Bench for decoder_scan_pipe: directed and randomized direct decode, backpressure, scan
// sequencing, reset during scan and an exhaustive decode sweep on two further geometries.
module tb_decoder_scan_pipe;

   localparam int IN_W  = 6;
   localparam int DWELL = 4;

`ifdef DECODER_SCAN_ACTIVE_LOW_EN
   localparam bit ACT_LOW = 1'b1;
`else
   localparam bit ACT_LOW = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic mode = 1'b0, in_valid = 1'b0, scan_start = 1'b0, scan_loop = 1'b0;
   logic scan_stop = 1'b0, out_ready = 1'b1;
   logic [IN_W-1:0] in_idx = '0, scan_last = '0;
   logic in_ready, out_valid, scan_busy, scan_done;
   logic [63:0] out;

   logic in4_valid = 1'b0, in4_ready, out4_valid, busy4, done4;
   logic [3:0] in4 = '0;
   logic [15:0] out4;
   logic in8_valid = 1'b0, in8_ready, out8_valid, busy8, done8;
   logic [7:0] in8 = '0;
   logic [255:0] out8;

   int pass_cnt = 0;
   int total_cnt = 0;

   decoder_scan_pipe #(.IN_W(6), .LO_W(3), .DWELL(4), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
      .in(in_idx), .scan_start(scan_start), .scan_last(scan_last), .scan_loop(scan_loop),
      .scan_stop(scan_stop), .out(out), .out_valid(out_valid), .out_ready(out_ready),
      .scan_busy(scan_busy), .scan_done(scan_done));

   decoder_scan_pipe #(.IN_W(4), .LO_W(1), .DWELL(4), .CNT_W(8)) dut4 (
      .clk(clk), .rst_n(rst_n), .mode(1'b0), .in_valid(in4_valid), .in_ready(in4_ready),
      .in(in4), .scan_start(1'b0), .scan_last(4'd0), .scan_loop(1'b0),
      .scan_stop(1'b0), .out(out4), .out_valid(out4_valid), .out_ready(1'b1),
      .scan_busy(busy4), .scan_done(done4));

   decoder_scan_pipe #(.IN_W(8), .LO_W(4), .DWELL(4), .CNT_W(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .mode(1'b0), .in_valid(in8_valid), .in_ready(in8_ready),
      .in(in8), .scan_start(1'b0), .scan_last(8'd0), .scan_loop(1'b0),
      .scan_stop(1'b0), .out(out8), .out_valid(out8_valid), .out_ready(1'b1),
      .scan_busy(busy8), .scan_done(done8));

   always #5 clk = ~clk;

   function automatic logic [63:0] code6(input int idx);
      logic [63:0] v;
      v = 64'd1 << idx;
      return ACT_LOW ? ~v : v;
   endfunction

   function automatic logic [63:0] off6();
      return ACT_LOW ? '1 : '0;
   endfunction

   function automatic logic [15:0] code4(input int idx);
      logic [15:0] v;
      v = 16'd1 << idx;
      return ACT_LOW ? ~v : v;
   endfunction

   function automatic logic [255:0] code8(input int idx);
      logic [255:0] v;
      v = 256'd1 << idx;
      return ACT_LOW ? ~v : v;
   endfunction

   task automatic idle_inputs();
      mode = 1'b0; in_valid = 1'b0; scan_start = 1'b0; scan_stop = 1'b0; scan_loop = 1'b0;
      out_ready = 1'b1;
   endtask

   task automatic test_reset();
      idle_inputs();
      #1 rst_n = 1'b0;
      #2;
      total_cnt++; if (out !== off6()) $display("FAIL rst_out: got %h want %h", out, off6()); else pass_cnt++;
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid); else pass_cnt++;
      total_cnt++; if (scan_busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", scan_busy); else pass_cnt++;
      total_cnt++; if (scan_done !== 1'b0) $display("FAIL rst_done: got %b want 0", scan_done); else pass_cnt++;
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b want 1", in_ready); else pass_cnt++;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      total_cnt++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL post_rst: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); else pass_cnt++;
   endtask

   task automatic test_direct();
      int vals[3];
      vals = '{0, 63, 27};
      idle_inputs();
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (c >= 2 && c <= 4) begin
            total_cnt++; if (out_valid !== 1'b1 || out !== code6(vals[c-2])) $display("FAIL direct_beat%0d: out=%h v=%b want %h v=1", c, out, out_valid, code6(vals[c-2])); else pass_cnt++;
         end else if (c >= 1) begin
            total_cnt++; if (out_valid !== 1'b0 || out !== off6()) $display("FAIL direct_bubble%0d: out=%h v=%b want %h v=0", c, out, out_valid, off6()); else pass_cnt++;
         end
         if (c < 3) begin
            in_valid = 1'b1; in_idx = IN_W'(vals[c]);
            #1;
            total_cnt++; if (in_ready !== 1'b1) $display("FAIL direct_ready%0d: got %b want 1", c, in_ready); else pass_cnt++;
         end else begin
            in_valid = 1'b0;
         end
      end
   endtask

   task automatic test_backpressure();
      idle_inputs();
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b1; in_idx = 6'd5;
      @(negedge clk);
      in_idx = 6'd9;
      #1;
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL bp_ready_empty: got %b want 1", in_ready); else pass_cnt++;
      @(negedge clk);
      in_idx = 6'd12;
      for (int s = 0; s < 3; s++) begin
         if (s > 0) @(negedge clk);
         #1;
         total_cnt++; if (out_valid !== 1'b1 || out !== code6(5)) $display("FAIL bp_hold%0d: out=%h v=%b want %h v=1", s, out, out_valid, code6(5)); else pass_cnt++;
         total_cnt++; if (in_ready !== 1'b0) $display("FAIL bp_ready_stall%0d: got %b want 0", s, in_ready); else pass_cnt++;
      end
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      total_cnt++; if (out !== code6(5) || in_ready !== 1'b1) $display("FAIL bp_release: out=%h in_ready=%b want %h/1", out, in_ready, code6(5)); else pass_cnt++;
      @(negedge clk);
      in_valid = 1'b0;
      total_cnt++; if (out_valid !== 1'b1 || out !== code6(9)) $display("FAIL bp_next9: out=%h v=%b want %h", out, out_valid, code6(9)); else pass_cnt++;
      @(negedge clk);
      total_cnt++; if (out_valid !== 1'b1 || out !== code6(12)) $display("FAIL bp_next12: out=%h v=%b want %h", out, out_valid, code6(12)); else pass_cnt++;
      @(negedge clk);
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL bp_empty: v=%b want 0", out_valid); else pass_cnt++;
   endtask

   task automatic test_random_direct();
      logic [IN_W-1:0] exp_q[$];
      logic [IN_W-1:0] e;
      logic [63:0] obs_out, prev_out;
      bit obs_valid, prev_stall, acc_prev;
      idle_inputs();
      prev_stall = 1'b0; acc_prev = 1'b0; prev_out = '0;
      for (int cyc = 0; cyc < 310; cyc++) begin
         @(negedge clk);
         obs_valid = out_valid; obs_out = out;
         if (prev_stall) begin
            total_cnt++; if (obs_out !== prev_out || !obs_valid) $display("FAIL rnd_stall_hold: out=%h v=%b want %h v=1", obs_out, obs_valid, prev_out); else pass_cnt++;
         end
         if (cyc < 300) begin
            if (!in_valid || acc_prev) begin
               in_valid = ($urandom_range(0, 3) != 0);
               in_idx = IN_W'($urandom_range(0, 63));
            end
            out_ready = ($urandom_range(0, 3) != 0);
         end else begin
            in_valid = 1'b0;
            out_ready = 1'b1;
         end
         #1;
         if (obs_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               total_cnt++; $display("FAIL rnd_extra_beat: out=%h with nothing expected", obs_out);
            end else begin
               e = exp_q.pop_front();
               total_cnt++; if (obs_out !== code6(int'(e))) $display("FAIL rnd_beat: out=%h want %h", obs_out, code6(int'(e))); else pass_cnt++;
            end
         end else if (!obs_valid) begin
            total_cnt++; if (obs_out !== off6()) $display("FAIL rnd_idle_out: out=%h want %h", obs_out, off6()); else pass_cnt++;
         end
         acc_prev = in_valid && in_ready;
         if (acc_prev) exp_q.push_back(in_idx);
         prev_stall = obs_valid && !out_ready;
         prev_out = obs_out;
      end
      total_cnt++; if (exp_q.size() != 0) $display("FAIL rnd_lost: %0d beats missing want 0", exp_q.size()); else pass_cnt++;
   endtask

   task automatic run_scan(input string name, input int last, input bit loop, input int stop_n, input bit rand_ready);
      int exp_seq[$];
      int n, beats, last_cyc, done_cnt, post;
      beats = 0; last_cyc = 0; done_cnt = 0; post = -1;
      n = loop ? stop_n : last + 1;
      for (int k = 0; k < n; k++) exp_seq.push_back(loop ? k % (last + 1) : k);
      idle_inputs();
      @(negedge clk);
      mode = 1'b1; scan_last = IN_W'(last); scan_loop = loop; scan_start = 1'b1;
      @(negedge clk);
      scan_start = 1'b0; mode = 1'b0;
      total_cnt++; if (scan_busy !== 1'b1) $display("FAIL %s_busy_start: got %b want 1", name, scan_busy); else pass_cnt++;
      for (int cyc = 0; cyc < 400; cyc++) begin
         out_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
         if (out_valid && out_ready) begin
            if (beats >= exp_seq.size()) begin
               total_cnt++; $display("FAIL %s_extra_beat: out=%h after %0d beats", name, out, beats);
            end else begin
               total_cnt++; if (out !== code6(exp_seq[beats])) $display("FAIL %s_beat%0d: out=%h want %h", name, beats, out, code6(exp_seq[beats])); else pass_cnt++;
            end
            if (!rand_ready && beats > 0) begin
               total_cnt++; if (cyc - last_cyc != DWELL) $display("FAIL %s_spacing: got %0d want %0d", name, cyc - last_cyc, DWELL); else pass_cnt++;
            end
            last_cyc = cyc;
            beats++;
            if (stop_n > 0 && beats == stop_n) scan_stop = 1'b1;
         end
         if (scan_done === 1'b1) begin
            done_cnt++;
            total_cnt++; if (scan_busy !== 1'b0) $display("FAIL %s_busy_at_done: got %b want 0", name, scan_busy); else pass_cnt++;
            if (post < 0) post = cyc;
         end
         if (post >= 0 && cyc >= post + 4) break;
         @(negedge clk);
      end
      scan_stop = 1'b0;
      total_cnt++; if (done_cnt != 1) $display("FAIL %s_done_count: got %0d want 1", name, done_cnt); else pass_cnt++;
      total_cnt++; if (beats != exp_seq.size()) $display("FAIL %s_beat_count: got %0d want %0d", name, beats, exp_seq.size()); else pass_cnt++;
      total_cnt++; if (scan_busy !== 1'b0) $display("FAIL %s_busy_end: got %b want 0", name, scan_busy); else pass_cnt++;
   endtask

   task automatic test_scan();
      run_scan("scan3", 3, 1'b0, 0, 1'b0);
   endtask

   task automatic test_scan_loop_stop();
      run_scan("loopstop", 2, 1'b1, 7, 1'b0);
      run_scan("loop0", 0, 1'b1, 3, 1'b0);
   endtask

   task automatic test_scan_random();
      run_scan("scanrnd", $urandom_range(0, 9), 1'b0, 0, 1'b1);
      run_scan("scanrnd_ready1", $urandom_range(0, 12), 1'b0, 0, 1'b0);
   endtask

   task automatic test_reset_mid_scan();
      int done_cnt;
      done_cnt = 0;
      idle_inputs();
      @(negedge clk);
      mode = 1'b1; scan_last = 6'd5; scan_loop = 1'b1; scan_start = 1'b1;
      @(negedge clk);
      scan_start = 1'b0; mode = 1'b0;
      repeat (6) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      total_cnt++; if (out !== off6()) $display("FAIL midrst_out: got %h want %h", out, off6()); else pass_cnt++;
      total_cnt++; if (out_valid !== 1'b0 || scan_busy !== 1'b0) $display("FAIL midrst_flags: v=%b busy=%b want 0/0", out_valid, scan_busy); else pass_cnt++;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (scan_done === 1'b1) done_cnt++;
      end
      total_cnt++; if (done_cnt != 0 || scan_busy !== 1'b0) $display("FAIL midrst_after: done_pulses=%0d busy=%b want 0/0", done_cnt, scan_busy); else pass_cnt++;
   endtask

   task automatic test_sweep();
      int p4[16];
      int p8[256];
      int q4[$];
      int q8[$];
      int i4, i8, b4, b8, j, t;
      i4 = 0; i8 = 0; b4 = 0; b8 = 0;
      for (int i = 0; i < 16; i++) p4[i] = i;
      for (int i = 0; i < 256; i++) p8[i] = i;
      for (int i = 15; i > 0; i--) begin j = $urandom_range(0, i); t = p4[i]; p4[i] = p4[j]; p4[j] = t; end
      for (int i = 255; i > 0; i--) begin j = $urandom_range(0, i); t = p8[i]; p8[i] = p8[j]; p8[j] = t; end
      for (int cyc = 0; cyc < 265; cyc++) begin
         @(negedge clk);
         if (out4_valid) begin
            b4++;
            if (q4.size() == 0) begin
               total_cnt++; $display("FAIL sweep4_extra: out=%h", out4);
            end else begin
               t = q4.pop_front();
               total_cnt++; if (out4 !== code4(t) || $countones(ACT_LOW ? ~out4 : out4) != 1) $display("FAIL sweep4_val: out=%h want %h", out4, code4(t)); else pass_cnt++;
            end
         end
         if (out8_valid) begin
            b8++;
            if (q8.size() == 0) begin
               total_cnt++; $display("FAIL sweep8_extra: out=%h", out8);
            end else begin
               t = q8.pop_front();
               total_cnt++; if (out8 !== code8(t) || $countones(ACT_LOW ? ~out8 : out8) != 1) $display("FAIL sweep8_val: in=%0d out=%h want %h", t, out8, code8(t)); else pass_cnt++;
            end
         end
         in4_valid = (i4 < 16);
         if (i4 < 16) in4 = 4'(p4[i4]);
         in8_valid = (i8 < 256);
         if (i8 < 256) in8 = 8'(p8[i8]);
         #1;
         if (in4_valid && in4_ready) begin q4.push_back(int'(in4)); i4++; end
         if (in8_valid && in8_ready) begin q8.push_back(int'(in8)); i8++; end
      end
      in4_valid = 1'b0; in8_valid = 1'b0;
      total_cnt++; if (b4 != 16 || q4.size() != 0) $display("FAIL sweep4_count: beats=%0d left=%0d want 16/0", b4, q4.size()); else pass_cnt++;
      total_cnt++; if (b8 != 256 || q8.size() != 0) $display("FAIL sweep8_count: beats=%0d left=%0d want 256/0", b8, q8.size()); else pass_cnt++;
      total_cnt++; if ((busy4 | done4 | busy8 | done8) !== 1'b0) $display("FAIL sweep_scan_flags: got %b%b%b%b want 0000", busy4, done4, busy8, done8); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_direct();
      test_backpressure();
      test_random_direct();
      test_scan();
      test_scan_loop_stop();
      test_scan_random();
      test_reset_mid_scan();
      test_sweep();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
